noc_packetizer: RTL

NOC_PACKETIZER -- requirements
Module: noc_packetizer

---
 rtl/noc_packetizer_pkg.sv | 61 ++++++
 rtl/noc_packetizer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/noc_packetizer_pkg.sv
// Shared types and header helpers for the NoC packetizer: FSM states,
// header field offsets and the header builder.
package noc_pkt_pkg;

  localparam int SEQ_WIDTH = 8;
  localparam int HDR_MAX   = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD
  } state_t;

  function automatic int off_dest_x();
    return 0;
  endfunction

  function automatic int off_dest_y(input int xw);
    return xw;
  endfunction

  function automatic int off_src_x(input int xw, input int yw);
    return xw + yw;
  endfunction

  function automatic int off_src_y(input int xw, input int yw);
    return 2 * xw + yw;
  endfunction

  function automatic int off_seq(input int xw, input int yw);
    return 2 * xw + 2 * yw;
  endfunction

  function automatic int hdr_width(input int xw, input int yw);
    return off_seq(xw, yw) + SEQ_WIDTH;
  endfunction

  // Fields are masked to their widths; bits above the seq field stay zero.
  function automatic logic [HDR_MAX-1:0] build_header(
    input int                   xw,
    input int                   yw,
    input logic [31:0]          dx,
    input logic [31:0]          dy,
    input logic [31:0]          sx,
    input logic [31:0]          sy,
    input logic [SEQ_WIDTH-1:0] seq
  );
    logic [HDR_MAX-1:0] h;
    logic [HDR_MAX-1:0] mx;
    logic [HDR_MAX-1:0] my;
    mx = (HDR_MAX'(1) << xw) - HDR_MAX'(1);
    my = (HDR_MAX'(1) << yw) - HDR_MAX'(1);
    h  = (HDR_MAX'(dx) & mx) << off_dest_x();
    h  = h | ((HDR_MAX'(dy) & my) << off_dest_y(xw));
    h  = h | ((HDR_MAX'(sx) & mx) << off_src_x(xw, yw));
    h  = h | ((HDR_MAX'(sy) & my) << off_src_y(xw, yw));
    h  = h | (HDR_MAX'(seq) << off_seq(xw, yw));
    return h;
  endfunction

endpackage

// File: rtl/noc_packetizer.sv
// Wraps core AXIS bursts into NoC packets: one header flit, then payload flits.
// Latency: header one cycle after in_tvalid; payload passes through combinationally.
// Backpressure: header held while out_tready=0; payload in_tready follows out_tready.
// Optional NOC_PKT_SPLIT_EN splits bursts into packets of at most MAX_PAYLOAD flits.
module noc_packetizer
  import noc_pkt_pkg::*;
#(
  parameter int  DATA_WIDTH    = 32,
  parameter int  MAX_ROUTERS_X = 4,
  parameter int  MAX_ROUTERS_Y = 4,
  parameter int  ROUTER_X      = 0,
  parameter int  ROUTER_Y      = 0,
  parameter int  MAX_PAYLOAD   = 4,
  localparam int X_W           = $clog2(MAX_ROUTERS_X),
  localparam int Y_W           = $clog2(MAX_ROUTERS_Y)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  input  logic                  in_tlast,
  input  logic [X_W-1:0]        in_dest_x,
  input  logic [Y_W-1:0]        in_dest_y,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic                  out_tlast
);

  localparam int HDR_W = hdr_width(X_W, Y_W);

  if (DATA_WIDTH < HDR_W) begin : g_width_err
    $error("noc_packetizer: DATA_WIDTH too small for header");
  end
  if (MAX_PAYLOAD < 1 || MAX_PAYLOAD > 255) begin : g_payload_err
    $error("noc_packetizer: MAX_PAYLOAD out of range 1..255");
  end

  state_t                 state;
  logic [SEQ_WIDTH-1:0]   seq;
  logic [X_W-1:0]         dest_x;
  logic [Y_W-1:0]         dest_y;
  logic                   split_hit;
  logic [DATA_WIDTH-1:0]  hdr;
  logic                   pay_xfer;

`ifdef NOC_PKT_SPLIT_EN
  logic [7:0] cnt;
  assign split_hit = (cnt == 8'(MAX_PAYLOAD - 1));
`else
  assign split_hit = 1'b0;
`endif

  assign hdr = DATA_WIDTH'(build_header(X_W, Y_W, 32'(dest_x), 32'(dest_y),
                                        32'(ROUTER_X), 32'(ROUTER_Y), seq));

  assign pay_xfer = (state == ST_PAYLOAD) && in_tvalid && out_tready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      seq    <= '0;
      dest_x <= '0;
      dest_y <= '0;
`ifdef NOC_PKT_SPLIT_EN
      cnt    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_tvalid) begin
            dest_x <= in_dest_x;
            dest_y <= in_dest_y;
            state  <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (out_tready) begin
            seq   <= seq + 1'b1;
`ifdef NOC_PKT_SPLIT_EN
            cnt   <= '0;
`endif
            state <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (pay_xfer) begin
`ifdef NOC_PKT_SPLIT_EN
            cnt <= cnt + 1'b1;
`endif
            // in_tlast wins over a coincident split so no empty packet follows
            if (in_tlast) begin
              state <= ST_IDLE;
            end else if (split_hit) begin
              state <= ST_HEADER;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are forced quiet while reset is asserted, not only after the edge.
  always_comb begin
    out_tvalid = 1'b0;
    out_tdata  = '0;
    out_tlast  = 1'b0;
    in_tready  = 1'b0;
    if (!rst_i) begin
      case (state)
        ST_HEADER: begin
          out_tvalid = 1'b1;
          out_tdata  = hdr;
        end
        ST_PAYLOAD: begin
          out_tvalid = in_tvalid;
          out_tdata  = in_tdata;
          out_tlast  = in_tlast | split_hit;
          in_tready  = out_tready;
        end
        default: ;
      endcase
    end
  end

endmodule
